// File: rtl/modul_scadere_pipeline.sv
// Pipelined unsigned subtractor: one WIDTH/STAGES-bit slice per stage, borrow rippled via stage registers.
// Optional SCADERE_SAT_EN: clamp diff to 0 in the last stage when the final borrow is set.
module modul_scadere_pipeline #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned SW = WIDTH / STAGES;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] bo_q, bo_d;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [WIDTH-1:0]  d_d [STAGES];
   logic              adv;

   function automatic logic [SW:0] sub_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic bi);
      return {1'b0, x} - {1'b0, y} - {{SW{1'b0}}, bi};
   endfunction

   // A stall freezes every stage, bubbles included.
   assign adv      = out_ready | ~valid_q[STAGES-1];
   assign in_ready = adv;

   always_comb begin
      logic [SW:0] res;
      res        = sub_slice(a[SW-1:0], b[SW-1:0], 1'b0);
      valid_d[0] = in_valid;
      a_d[0]     = a;
      b_d[0]     = b;
      d_d[0]     = '0;
      d_d[0][SW-1:0] = res[SW-1:0];
      bo_d[0]    = res[SW];
      for (int unsigned k = 1; k < STAGES; k++) begin
         res        = sub_slice(a_q[k-1][k*SW +: SW], b_q[k-1][k*SW +: SW], bo_q[k-1]);
         valid_d[k] = valid_q[k-1];
         a_d[k]     = a_q[k-1];
         b_d[k]     = b_q[k-1];
         d_d[k]     = d_q[k-1];
         d_d[k][k*SW +: SW] = res[SW-1:0];
         bo_d[k]    = res[SW];
      end
`ifdef SCADERE_SAT_EN
      if (bo_d[STAGES-1]) d_d[STAGES-1] = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         bo_q    <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            d_q[k] <= '0;
         end
      end else if (adv) begin
         valid_q <= valid_d;
         bo_q    <= bo_d;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            d_q[k] <= d_d[k];
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign diff      = d_q[STAGES-1];
   assign borrow    = bo_q[STAGES-1];

endmodule

// File: tb/tb_modul_scadere_pipeline.sv
// Self-checking bench for modul_scadere_pipeline (WIDTH=16, STAGES=4); reference model is plain a-b.
module tb_modul_scadere_pipeline;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        borrow;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   modul_scadere_pipeline #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] d;
      logic        bw;
      d  = x - y;
      bw = (x < y);
`ifdef SCADERE_SAT_EN
      if (bw) d = 16'h0000;
`endif
      return {bw, d};
   endfunction

   // One cycle: drive inputs after the falling edge, sample outputs 1ns later.
   task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ordy, output logic ov, output logic [15:0] od,
                       output logic ob, output logic ir);
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      out_ready = ordy;
      #1;
      ov = out_valid;
      od = diff;
      ob = borrow;
      ir = in_ready;
   endtask

   task automatic test_reset();
      logic ov, ob, ir;
      logic [15:0] od;
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff got %h want 0000", diff); end
      checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h1111 * (i + 1)), 16'h0001, 1'b0, ov, od, ob, ir);
      step(1'b0, '0, '0, 1'b0, ov, od, ob, ir);
      checks++; if (ov !== 1'b1 || ir !== 1'b0) begin errors++; $display("FAIL full_pipe got ov=%b ir=%b want ov=1 ir=0", ov, ir); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b want 0", out_valid); end
      checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL async_reset_diff got %h want 0000", diff); end
      checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL async_reset_borrow got %b want 0", borrow); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [15:0] ta [6] = '{16'h1234, 16'h1000, 16'h0000, 16'hA5A5, 16'h0000, 16'hFFFF};
      logic [15:0] tbv[6] = '{16'h0034, 16'h0001, 16'h0001, 16'hA5A5, 16'hFFFF, 16'h0000};
      logic ov, ob, ir;
      logic [15:0] od;
      logic [16:0] exp;
      int lat;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, ta[i], tbv[i], 1'b1, ov, od, ob, ir);
         checks++; if (ir !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got in_ready=%b want 1", i, ir); end
         lat = 0;
         for (int c = 1; c <= 8 && lat == 0; c++) begin
            step(1'b0, '0, '0, 1'b1, ov, od, ob, ir);
            if (ov === 1'b1) begin
               lat = c;
               exp = model(ta[i], tbv[i]);
               checks++; if (od !== exp[15:0]) begin errors++; $display("FAIL dir%0d_diff got %h want %h", i, od, exp[15:0]); end
               checks++; if (ob !== exp[16]) begin errors++; $display("FAIL dir%0d_borrow got %b want %b", i, ob, exp[16]); end
            end
         end
         checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
      end
   endtask

   task automatic test_back_to_back();
      logic ov, ob, ir, iv, ordy;
      logic [15:0] od, na, nb, held;
      logic [31:0] e;
      logic [16:0] exp;
      int sent = 0, got = 0;
      held = '0;
      sb.delete();
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         iv   = (sent < 8);
         ordy = !(cyc >= 6 && cyc < 9);
         na   = 16'($urandom);
         nb   = 16'($urandom);
         step(iv, na, nb, ordy, ov, od, ob, ir);
         if (!ordy) begin
            checks++; if (ir !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL b2b_stall_c%0d got ir=%b ov=%b want ir=0 ov=1", cyc, ir, ov); end
            if (cyc > 6) begin
               checks++; if (od !== held) begin errors++; $display("FAIL b2b_hold_c%0d got %h want %h", cyc, od, held); end
            end
            held = od;
         end
         if (ov && ordy) begin
            got++;
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL b2b_extra got diff=%h want no output", od);
            end else begin
               e = sb.pop_front();
               exp = model(e[31:16], e[15:0]);
               checks++; if ({ob, od} !== exp) begin errors++; $display("FAIL b2b_result got %b/%h want %b/%h", ob, od, exp[16], exp[15:0]); end
            end
         end
         if (iv && ir) begin sb.push_back({na, nb}); sent++; end
      end
      checks++; if (got != 8 || sb.size() != 0) begin errors++; $display("FAIL b2b_count got %0d want 8", got); end
   endtask

   task automatic test_random();
      logic ov, ob, ir, iv, ordy;
      logic [15:0] od, na, nb;
      logic [31:0] e;
      logic [16:0] exp;
      int bad = 0, delivered = 0, accepted = 0;
      sb.delete();
      for (int cyc = 0; cyc < 340; cyc++) begin
         iv   = (cyc < 300) && ($urandom_range(0, 3) != 0);
         ordy = (cyc >= 300) || ($urandom_range(0, 2) != 0);
         na   = 16'($urandom);
         nb   = ($urandom_range(0, 4) == 0) ? na : 16'($urandom);
         if ($urandom_range(0, 7) == 0) na = 16'h0000;
         step(iv, na, nb, ordy, ov, od, ob, ir);
         if (ov && ordy) begin
            delivered++;
            if (sb.size() == 0) bad++;
            else begin
               e = sb.pop_front();
               exp = model(e[31:16], e[15:0]);
               checks++;
               if ({ob, od} !== exp) begin
                  errors++;
                  $display("FAIL rand_result a=%h b=%h got %b/%h want %b/%h", e[31:16], e[15:0], ob, od, exp[16], exp[15:0]);
               end
            end
         end
         if (iv && ir) begin sb.push_back({na, nb}); accepted++; end
      end
      checks++; if (bad != 0 || sb.size() != 0 || delivered != accepted) begin
         errors++; $display("FAIL rand_count got %0d delivered want %0d", delivered, accepted);
      end
   endtask

   task automatic test_reset_midflight();
      logic ov, ob, ir;
      logic [15:0] od;
      logic [16:0] exp;
      int lat = 0, spurious = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h4000 + i), 16'h0100, 1'b1, ov, od, ob, ir);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b want 0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step(1'b0, '0, '0, 1'b1, ov, od, ob, ir);
         if (ov !== 1'b0) spurious++;
      end
      checks++; if (spurious != 0) begin errors++; $display("FAIL mid_reset_ghost got %0d outputs want 0", spurious); end
      step(1'b1, 16'h8000, 16'h0001, 1'b1, ov, od, ob, ir);
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         step(1'b0, '0, '0, 1'b1, ov, od, ob, ir);
         if (ov === 1'b1) begin
            lat = c;
            exp = model(16'h8000, 16'h0001);
            checks++; if ({ob, od} !== exp) begin errors++; $display("FAIL mid_reset_result got %b/%h want %b/%h", ob, od, exp[16], exp[15:0]); end
         end
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL mid_reset_latency got %0d want 4", lat); end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
